microcycle_sequencer: RTL
=========================

# microcycle_sequencer

Generates the per-microinstruction phase timing (T1..T5) and the MIR load strobe for the decoding card. Also owns the shift-loop counter that runs the shift registers for a programmed number of clocks via ACTLOOP. Sits beside the decoding card; its outputs drive T1, T3, T5, MIRKL and ACTLOOP there. Its WSHC and MIR15 inputs come back from the decoding card.

## Interface
- SHCW, default 6: width of the shift-loop count register.
- clk  input  1  system clock; all state changes on its rising edge.
- MCL  input  1  master clear; reset is asynchronous and active-high.
- RUN  input  1  permits leaving IDLE; sampled in IDLE only.
- STOP  input  1  halt request; sampled in T5 only.
- MWAIT  input  1  memory wait; holds the sequencer in T2 while high.
- LOOPEN  input  1  the current microinstruction requests a shift loop; sampled in T3.
- WSHC  input  1  write strobe for the shift count; effective in T3 only.
- SHCIN  input  SHCW  new shift count value.
- T1, T2, T3, T4, T5  output  1 each  one-hot phase outputs; all low in IDLE and LOOP.
- MIRKL  output  1  MIR load enable; equals T5.
- ACTLOOP  output  1  high in LOOP; enables shifting for one clock per step.
- SHC  output  SHCW  current shift count.
- RUNNING  output  1  high in any state except IDLE.
- CYCDONE  output  1  one-clock pulse in T5; counts completed microcycles.

## Operation
- States: IDLE, T1, T2, T3, LOOP, T4, T5. State is a registered, one-hot encoding. All outputs except SHC are decoded combinationally from the state register.
- IDLE → T1 when RUN=1; otherwise the sequencer stays in IDLE.
- T1 → T2.
- T2 → T3 when MWAIT=0; otherwise the sequencer stays in T2.
- T3 → LOOP when LOOPEN=1 and SHC≠0; otherwise T3 → T4.
- LOOP: ACTLOOP=1 and SHC decrements by 1 on each clock.
  - LOOP → T4 on the clock where SHC==1, so SHC reads 0 on entry to T4.
  - LOOP therefore lasts exactly the pre-loop SHC value, in clocks.
- T4 → T5.
- T5 → IDLE when STOP=1; otherwise T5 → T1.
- Shift count register:
  - WSHC=1 in T3 loads SHCIN into SHC at the end of T3.
  - WSHC in any other state is ignored.
  - When WSHC and LOOPEN are both set in the same T3, the loop decision uses the old SHC value. The new value is loaded and is used by later loops only; the load takes priority over any decrement.
  - SHC is held in every state other than T3 (load) and LOOP (decrement).
  - SHC never wraps: a loop is never entered with SHC=0.
- LOOPEN with SHC=0 gives no LOOP state, and ACTLOOP stays low.
- MWAIT is ignored outside T2. RUN is ignored outside IDLE. STOP is ignored outside T5.

## Timing
- Reset (MCL=1, asynchronous):
  - State becomes IDLE and SHC becomes 0.
  - T1..T5, MIRKL, ACTLOOP, RUNNING and CYCDONE are all 0.
  - Asserting MCL mid-cycle or mid-loop aborts immediately, with no completion of T5.
- First T1 appears 1 clock after the first edge where RUN=1 is sampled in IDLE with MCL low.
- An unstalled, loop-free microcycle is exactly 5 clocks. Back-to-back microcycles go T5 → T1 with no gap.
- Microcycle length is 5 + (MWAIT stall clocks) + (loop count, when a loop is taken).
- MIRKL is high throughout T5, so the decoding card captures ROM on the T5 → T1 edge. The new MIR contents are therefore valid during the following T1.
- After STOP, the return to T1 from IDLE requires RUN, and T1 follows 1 clock later.

## Test plan
- Reset values: assert MCL asynchronously mid-T3 → all outputs 0 and SHC=0 within the same clock, before the next edge. Release MCL with RUN=1 → T1 on the next clock.
- Basic cycle: RUN=1, MWAIT=0, LOOPEN=0 → repeating phases T1,T2,T3,T4,T5, one clock each. MIRKL and CYCDONE are high only in T5.
- Shift loop: WSHC=1 with SHCIN=3 in cycle N, then LOOPEN=1 in cycle N+1 → ACTLOOP high for exactly 3 clocks after T3, SHC reading 3,2,1, then T4 with SHC=0.
- Same-T3 collision: SHC=2 before T3, with WSHC=1, SHCIN=5 and LOOPEN=1 in that T3 → a 2-clock loop, then SHC=5 on entry to T4. LOOPEN with SHC=0 → T3 goes directly to T4.
- Wait stretch: MWAIT=1 for 2 clocks starting in T2 → T2 is held for 3 clocks and the cycle is 7 clocks long. MWAIT pulsed during T4 → no effect.
- Stop/restart: STOP=1 in T5 → IDLE and RUNNING=0. Raising RUN 4 clocks later → T1 on the next clock. Asserting MCL mid-LOOP with SHC=4 → IDLE, SHC=0 and ACTLOOP=0 immediately.

Source files
------------

// File: rtl/microcycle_sequencer_if.sv
// Handshake/bus bundle between the microcycle sequencer and the decoding card.
// The sequencer uses the slave modport; the decoding card side uses master.
interface microcycle_sequencer_if #(
    parameter int SHCW = 6
);
    logic            RUN;
    logic            STOP;
    logic            MWAIT;
    logic            LOOPEN;
    logic            WSHC;
    logic [SHCW-1:0] SHCIN;

    logic            T1;
    logic            T2;
    logic            T3;
    logic            T4;
    logic            T5;
    logic            MIRKL;
    logic            ACTLOOP;
    logic [SHCW-1:0] SHC;
    logic            RUNNING;
    logic            CYCDONE;

    modport master (
        output RUN, STOP, MWAIT, LOOPEN, WSHC, SHCIN,
        input  T1, T2, T3, T4, T5, MIRKL, ACTLOOP, SHC, RUNNING, CYCDONE
    );

    modport slave (
        input  RUN, STOP, MWAIT, LOOPEN, WSHC, SHCIN,
        output T1, T2, T3, T4, T5, MIRKL, ACTLOOP, SHC, RUNNING, CYCDONE
    );
endinterface

// File: rtl/microcycle_sequencer.sv
// Microinstruction phase sequencer (T1..T5, MIR load strobe) with the
// shift-loop counter that drives ACTLOOP for a programmed number of clocks.
module microcycle_sequencer #(
    parameter int SHCW = 6
) (
    input  logic                    clk,
    input  logic                    MCL,
    microcycle_sequencer_if.slave   bus
);
    localparam logic [6:0] S_IDLE = 7'b0000001;
    localparam logic [6:0] S_T1   = 7'b0000010;
    localparam logic [6:0] S_T2   = 7'b0000100;
    localparam logic [6:0] S_T3   = 7'b0001000;
    localparam logic [6:0] S_LOOP = 7'b0010000;
    localparam logic [6:0] S_T4   = 7'b0100000;
    localparam logic [6:0] S_T5   = 7'b1000000;

    localparam logic [SHCW-1:0] SHC_ONE = SHCW'(1);

    logic [6:0]      state;
    logic [6:0]      state_nx;
    logic [SHCW-1:0] shc;
    logic [SHCW-1:0] pend_val;
    logic            pend_vld;
    logic            loop_take;
    logic            loop_last;

    assign loop_take = (state == S_T3) && bus.LOOPEN && (shc != '0);
    assign loop_last = (shc <= SHC_ONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = bus.RUN ? S_T1 : S_IDLE;
            S_T1:    state_nx = S_T2;
            S_T2:    state_nx = bus.MWAIT ? S_T2 : S_T3;
            S_T3:    state_nx = loop_take ? S_LOOP : S_T4;
            S_LOOP:  state_nx = loop_last ? S_T4 : S_LOOP;
            S_T4:    state_nx = S_T5;
            S_T5:    state_nx = bus.STOP ? S_IDLE : S_T1;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge MCL) begin
        if (MCL) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A count written in the same T3 that starts a loop is parked until the
    // loop ends, so the running loop keeps counting down the old value.
    always_ff @(posedge clk or posedge MCL) begin
        if (MCL) begin
            shc      <= '0;
            pend_val <= '0;
            pend_vld <= 1'b0;
        end else if (state == S_T3) begin
            if (bus.WSHC) begin
                if (loop_take) begin
                    pend_val <= bus.SHCIN;
                    pend_vld <= 1'b1;
                end else begin
                    shc <= bus.SHCIN;
                end
            end
        end else if (state == S_LOOP) begin
            if (loop_last && pend_vld) begin
                shc      <= pend_val;
                pend_vld <= 1'b0;
            end else if (shc != '0) begin
                shc <= shc - SHC_ONE;
            end
        end
    end

    assign bus.T1      = (state == S_T1);
    assign bus.T2      = (state == S_T2);
    assign bus.T3      = (state == S_T3);
    assign bus.T4      = (state == S_T4);
    assign bus.T5      = (state == S_T5);
    assign bus.MIRKL   = (state == S_T5);
    assign bus.CYCDONE = (state == S_T5);
    assign bus.ACTLOOP = (state == S_LOOP);
    assign bus.RUNNING = (state != S_IDLE);
    assign bus.SHC     = shc;
endmodule
